switch_in_port: RTL and testbench

Z80 I/O input port that returns the SBC DIP switches to the CPU: synchronizes and debounces eight raw switch lines, presents them on IN port FF, and presents a change/overrun status byte on IN port FE. It is the input-side counterpart of the LED bar display path. It drives the CPU data-in multiplexer with a read-data bus and a select flag, and runs entirely in the pll0_100MHz domain.

---
 rtl/switch_in_port.sv | 172 +++++++++++++++++
 tb/tb_switch_in_port.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_in_port.sv
// rtl/switch_in_port.sv - DIP switch IN port: sync, debounce, FF data / FE change-status with clear-on-read
module switch_in_port #(
    parameter int TICK_DIV   = 100000,
    parameter int DB_SAMPLES = 4
) (
    input  logic       pll0_100MHz,
    input  logic       reset,
    input  logic [7:0] swRaw,
    input  logic [7:0] cpuAddr,
    input  logic       cpuIORQ_n,
    input  logic       cpuRD_n,
    input  logic       cpuM1_n,
    output logic [7:0] portInData,
    output logic       portInSel,
    output logic [7:0] swState
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    logic [7:0] sw_meta;
    logic [7:0] sw_sync_raw;
    logic [7:0] sw_sync;

    always_ff @(posedge pll0_100MHz) begin
        if (reset) begin
            sw_meta     <= '0;
            sw_sync_raw <= '0;
        end else begin
            sw_meta     <= swRaw;
            sw_sync_raw <= sw_meta;
        end
    end

    // Switches pull low when DOWN, so invert to get 1 = DOWN.
    assign sw_sync = ~sw_sync_raw;

    logic [CNT_W-1:0] tick_cnt;
    logic             tick;

    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge pll0_100MHz) begin
        if (reset || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CNT_W'(1);
        end
    end

    logic [DB_SAMPLES-1:0][7:0] hist;
    logic [DB_SAMPLES-1:0][7:0] hist_nxt;
    logic [7:0]                 sw_state;
    logic [7:0]                 state_nxt;
    logic                       chg_evt;

    assign hist_nxt = {hist[DB_SAMPLES-2:0], sw_sync};

    // Acceptance looks at the history as it will be after this tick's shift,
    // so swState moves together with the shift and then holds until the next tick.
    always_comb begin
        logic all_one;
        logic all_zero;
        state_nxt = sw_state;
        all_one   = 1'b0;
        all_zero  = 1'b0;
        if (tick) begin
            for (int b = 0; b < 8; b++) begin
                all_one  = 1'b1;
                all_zero = 1'b1;
                for (int i = 0; i < DB_SAMPLES; i++) begin
                    all_one  = all_one & hist_nxt[i][b];
                    all_zero = all_zero & ~hist_nxt[i][b];
                end
                if (all_one) begin
                    state_nxt[b] = 1'b1;
                end else if (all_zero) begin
                    state_nxt[b] = 1'b0;
                end
            end
        end
    end

    assign chg_evt = |(state_nxt ^ sw_state);

    always_ff @(posedge pll0_100MHz) begin
        if (reset) begin
            hist     <= '0;
            sw_state <= '0;
        end else begin
            if (tick) begin
                hist <= hist_nxt;
            end
            sw_state <= state_nxt;
        end
    end

    assign swState = sw_state;

    logic       rd_act;
    logic       addr_hit;
    logic [0:0] trk_state;
    logic       lat_fe;
    logic       cur_fe;
    logic       clr_pulse;
    logic       st_chg;
    logic       st_ovr;
    logic [7:0] status_byte;

    assign addr_hit = (cpuAddr == 8'hFF) || (cpuAddr == 8'hFE);
    assign rd_act   = !cpuIORQ_n && !cpuRD_n && cpuM1_n && addr_hit;

    // Once a cycle is active the latched address decides what is returned.
    assign cur_fe    = (trk_state == ST_ACTIVE) ? lat_fe : (cpuAddr == 8'hFE);
    assign clr_pulse = (trk_state == ST_ACTIVE) && !rd_act && lat_fe;

    always_ff @(posedge pll0_100MHz) begin
        if (reset) begin
            trk_state <= ST_IDLE;
            lat_fe    <= 1'b0;
        end else begin
            case (trk_state)
                ST_IDLE: begin
                    if (rd_act) begin
                        trk_state <= ST_ACTIVE;
                        lat_fe    <= (cpuAddr == 8'hFE);
                    end
                end
                default: begin
                    if (!rd_act) begin
                        trk_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // A change landing on the clear clock wins so no event is ever lost.
    always_ff @(posedge pll0_100MHz) begin
        if (reset) begin
            st_chg <= 1'b0;
            st_ovr <= 1'b0;
        end else if (chg_evt) begin
            st_chg <= 1'b1;
            st_ovr <= st_ovr | st_chg;
        end else if (clr_pulse) begin
            st_chg <= 1'b0;
            st_ovr <= 1'b0;
        end
    end

    assign status_byte = {6'b0, st_ovr, st_chg};

    always_ff @(posedge pll0_100MHz) begin
        if (reset) begin
            portInSel  <= 1'b0;
            portInData <= '0;
        end else begin
            portInSel <= rd_act;
            if (!rd_act) begin
                portInData <= '0;
            end else if (cur_fe) begin
                portInData <= status_byte;
            end else begin
                portInData <= sw_state;
            end
        end
    end

endmodule

// File: tb/tb_switch_in_port.sv
// tb/tb_switch_in_port.sv - table, directed and random checks of switch_in_port against a queue-based model
module tb_switch_in_port;

    localparam int TD = 4;
    localparam int DB = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] swRaw = 8'h00;
    logic [7:0] cpuAddr = 8'h00;
    logic       cpuIORQ_n = 1'b1;
    logic       cpuRD_n = 1'b1;
    logic       cpuM1_n = 1'b1;
    logic [7:0] portInData;
    logic       portInSel;
    logic [7:0] swState;

    switch_in_port #(.TICK_DIV(TD), .DB_SAMPLES(DB)) dut (
        .pll0_100MHz(clk),
        .reset(reset),
        .swRaw(swRaw),
        .cpuAddr(cpuAddr),
        .cpuIORQ_n(cpuIORQ_n),
        .cpuRD_n(cpuRD_n),
        .cpuM1_n(cpuM1_n),
        .portInData(portInData),
        .portInSel(portInSel),
        .swState(swState)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: raw samples, tick-time history queue, status flags, read tracking.
    logic [7:0] raw_q[$];
    logic [7:0] hist[$];
    int         m_n;
    logic [7:0] m_state;
    logic       m_chg, m_ovr;
    logic       m_in_cycle, m_lat_fe;
    logic       e_sel;
    logic [7:0] e_data, e_state;

    task automatic model_edge();
        logic       rd;
        logic       use_fe;
        logic       clr;
        logic       chg;
        logic [7:0] sync;
        logic [7:0] ns;
        if (reset) begin
            raw_q = '{8'h00, 8'h00};
            hist = '{8'h00, 8'h00, 8'h00};
            m_n = 0;
            m_state = 8'h00;
            m_chg = 0; m_ovr = 0;
            m_in_cycle = 0; m_lat_fe = 0;
            e_sel = 0; e_data = 0; e_state = 0;
            return;
        end
        rd = !cpuIORQ_n && !cpuRD_n && cpuM1_n && (cpuAddr == 8'hFF || cpuAddr == 8'hFE);
        use_fe = m_in_cycle ? m_lat_fe : (cpuAddr == 8'hFE);
        e_sel = rd;
        e_data = !rd ? 8'h00 : (use_fe ? {6'b0, m_ovr, m_chg} : m_state);
        clr = m_in_cycle && !rd && m_lat_fe;
        if (!m_in_cycle && rd) begin
            m_in_cycle = 1;
            m_lat_fe = (cpuAddr == 8'hFE);
        end else if (m_in_cycle && !rd) begin
            m_in_cycle = 0;
        end
        sync = ~raw_q[0];
        raw_q.push_back(swRaw);
        void'(raw_q.pop_front());
        m_n++;
        ns = m_state;
        if (m_n % TD == 0) begin
            hist.push_back(sync);
            void'(hist.pop_front());
            for (int b = 0; b < 8; b++) begin
                bit same = 1;
                foreach (hist[k]) if (hist[k][b] != hist[0][b]) same = 0;
                if (same) ns[b] = hist[0][b];
            end
        end
        chg = (ns != m_state);
        if (chg) begin
            m_ovr = m_ovr | m_chg;
            m_chg = 1;
        end else if (clr) begin
            m_chg = 0;
            m_ovr = 0;
        end
        m_state = ns;
        e_state = ns;
    endtask

    function automatic bit predict_accept();
        logic [7:0] s, eq;
        if ((m_n + 1) % TD != 0) return 0;
        s = ~raw_q[0];
        eq = ~(hist[1] ^ hist[2]) & ~(hist[2] ^ s);
        return |(eq & (s ^ m_state));
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("model", {15'b0, portInSel, portInData, swState}, {15'b0, e_sel, e_data, e_state});
    endtask

    task automatic bus(input logic [7:0] a, input logic iorq_n, input logic rd_n, input logic m1_n);
        cpuAddr = a; cpuIORQ_n = iorq_n; cpuRD_n = rd_n; cpuM1_n = m1_n;
    endtask

    task automatic fe_read(output logic [7:0] d);
        bus(8'hFE, 0, 0, 1);
        step();
        d = portInData;
        step();
        bus(8'hFE, 1, 1, 1);
        step();
    endtask

    typedef struct {
        logic [7:0] addr;
        logic       iorq_n;
        logic       rd_n;
        logic       m1_n;
        logic       exp_sel;
        logic [7:0] exp_data;
    } vec_t;

    function automatic vec_t mk(input logic [7:0] a, input logic i, input logic r, input logic m,
                                input logic s, input logic [7:0] d);
        vec_t v;
        v.addr = a; v.iorq_n = i; v.rd_n = r; v.m1_n = m; v.exp_sel = s; v.exp_data = d;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        logic [7:0] d;
        bit released;
        int busy;

        // With swState=A5 and status=03 (two accepted changes) when the table runs.
        tbl.push_back(mk(8'hFF, 1, 1, 1, 0, 8'h00));
        for (int i = 0; i < 6; i++) tbl.push_back(mk(8'hFF, 0, 0, 1, 1, 8'hA5));
        tbl.push_back(mk(8'hFF, 1, 1, 1, 0, 8'h00));
        tbl.push_back(mk(8'hFF, 0, 0, 0, 0, 8'h00));
        tbl.push_back(mk(8'hFF, 0, 0, 0, 0, 8'h00));
        tbl.push_back(mk(8'hFD, 0, 0, 1, 0, 8'h00));
        tbl.push_back(mk(8'hFD, 0, 0, 1, 0, 8'h00));
        tbl.push_back(mk(8'hFE, 0, 1, 1, 0, 8'h00));
        tbl.push_back(mk(8'hFF, 1, 0, 1, 0, 8'h00));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(8'hFE, 0, 0, 1, 1, 8'h03));
        tbl.push_back(mk(8'hFE, 1, 1, 1, 0, 8'h00));
        tbl.push_back(mk(8'hFE, 0, 0, 1, 1, 8'h00));
        tbl.push_back(mk(8'hFE, 0, 0, 1, 1, 8'h00));
        tbl.push_back(mk(8'hFE, 1, 1, 1, 0, 8'h00));

        step();
        step();
        check("reset_outputs", {15'b0, portInSel, portInData, swState}, 32'h0);
        reset = 0;
        for (int i = 0; i < 16; i++) step();
        check("reset_all_down", {24'b0, swState}, 32'hFF);

        swRaw = 8'h5A;
        for (int i = 0; i < 20; i++) step();
        check("state_a5", {24'b0, swState}, 32'hA5);

        foreach (tbl[i]) begin
            bus(tbl[i].addr, tbl[i].iorq_n, tbl[i].rd_n, tbl[i].m1_n);
            step();
            check($sformatf("tbl%0d_sel", i), {31'b0, portInSel}, {31'b0, tbl[i].exp_sel});
            check($sformatf("tbl%0d_data", i), {24'b0, portInData}, {24'b0, tbl[i].exp_data});
        end

        swRaw = 8'h5B;
        for (int i = 0; i < 8; i++) step();
        swRaw = 8'h5A;
        for (int i = 0; i < 20; i++) step();
        check("glitch_state", {24'b0, swState}, 32'hA5);
        fe_read(d);
        check("glitch_status", {24'b0, d}, 32'h00);

        swRaw = 8'h5B;
        for (int i = 0; i < 20; i++) step();
        check("accept_state", {24'b0, swState}, 32'hA4);
        fe_read(d);
        check("accept_status", {24'b0, d}, 32'h01);

        // Release the FE read exactly on the clock where the model says a change is accepted.
        swRaw = 8'h5F;
        bus(8'hFE, 0, 0, 1);
        step();
        released = 0;
        for (int i = 0; i < 40 && !released; i++) begin
            if (predict_accept()) begin
                bus(8'hFE, 1, 1, 1);
                released = 1;
            end
            step();
        end
        check("simul_found", {31'b0, released}, 32'h1);
        bus(8'hFE, 1, 1, 1);
        step();
        fe_read(d);
        check("simul_status", {24'b0, d}, 32'h01);
        check("simul_state", {24'b0, swState}, 32'hA0);

        bus(8'hFF, 0, 0, 1);
        step();
        reset = 1;
        step();
        check("midcycle_reset", {15'b0, portInSel, portInData, swState}, 32'h0);
        reset = 0;
        bus(8'hFF, 1, 1, 1);
        step();

        busy = 0;
        for (int it = 0; it < 3000; it++) begin
            if ($urandom_range(0, 7) == 0) swRaw = swRaw ^ (8'h01 << $urandom_range(0, 7));
            if ($urandom_range(0, 63) == 0) swRaw = 8'($urandom);
            if (busy == 0) begin
                if ($urandom_range(0, 3) == 0) begin
                    case ($urandom_range(0, 3))
                        0: cpuAddr = 8'hFF;
                        1: cpuAddr = 8'hFE;
                        2: cpuAddr = 8'hFD;
                        default: cpuAddr = 8'($urandom);
                    endcase
                    cpuIORQ_n = 0;
                    cpuRD_n = ($urandom_range(0, 7) == 0);
                    cpuM1_n = ($urandom_range(0, 7) != 0);
                    busy = $urandom_range(1, 6);
                end else begin
                    bus(8'($urandom), 1, 1, 1);
                end
            end else begin
                busy--;
                if (busy == 0) bus(cpuAddr, 1, 1, 1);
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
